// File: rtl/fp_add_sub_seq.sv
// fp_add_sub_seq: multi-cycle IEEE-754-style adder/subtractor with RNE rounding and over/underflow flags
module fp_add_sub_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 ready,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic [1:0]           ofuf
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam logic [EXP_W:0] E1 = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EMAX = (EXP_W+1)'((1 << EXP_W) - 1);
  localparam logic [EXP_W:0] DMAX = (EXP_W+1)'(MAN_W + 3);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state_q, state_d;
  logic sign_q, sign_d, eop_q, eop_d, spec_q, spec_d;
  logic [EXP_W:0] exp_q, exp_d, diff_q, diff_d, rexp;
  logic [SW-1:0] ma_q, ma_d, mb_q, mb_d;
  logic [SW:0] sum_q, sum_d;
  logic [W-1:0] res_q, res_d, sres_q, sres_d, y, big, sml, inf;
  logic [1:0] ofuf_q, ofuf_d;
  logic [MAN_W:0] rnd;
  logic x_inf, y_inf, x_zero, y_zero, swap;
  assign y = {b[W-1] ^ sub, b[W-2:0]};
  assign x_inf = &a[W-2:MAN_W];
  assign y_inf = &y[W-2:MAN_W];
  assign x_zero = ~|a[W-2:MAN_W];
  assign y_zero = ~|y[W-2:MAN_W];
  assign swap = y[W-2:0] > a[W-2:0];
  assign big = swap ? y : a;
  assign sml = swap ? a : y;
  assign inf = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  // fraction-only increment: a carry out means the significand became 10.0, so bump the exponent
  assign rnd = {1'b0, sum_q[SW-2:3]} + {{MAN_W{1'b0}}, sum_q[2] & (|sum_q[1:0] | sum_q[3])};
  assign rexp = exp_q + {{EXP_W{1'b0}}, rnd[MAN_W]};
  assign ready = state_q == IDLE;
  assign done = state_q == DONE;
  assign result = res_q;
  assign ofuf = ofuf_q;
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    eop_d = eop_q;
    spec_d = spec_q;
    exp_d = exp_q;
    diff_d = diff_q;
    ma_d = ma_q;
    mb_d = mb_q;
    sum_d = sum_q;
    res_d = res_q;
    sres_d = sres_q;
    ofuf_d = ofuf_q;
    case (state_q)
      IDLE: if (start) begin
        spec_d = x_inf | y_inf | x_zero | y_zero;
        sres_d = (x_inf & y_inf & (a[W-1] ^ y[W-1])) ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}}
               : x_inf ? {a[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}}
               : y_inf ? {y[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}}
               : (x_zero & y_zero) ? {a[W-1] & y[W-1], {(W-1){1'b0}}}
               : x_zero ? y : a;
        sign_d = big[W-1];
        eop_d = big[W-1] ^ sml[W-1];
        exp_d = {1'b0, big[W-2:MAN_W]};
        diff_d = {1'b0, big[W-2:MAN_W]} - {1'b0, sml[W-2:MAN_W]};
        ma_d = {1'b1, big[MAN_W-1:0], 3'b000};
        mb_d = {1'b1, sml[MAN_W-1:0], 3'b000};
        state_d = (spec_d | ~|diff_d) ? ADD : ALIGN;
      end
      ALIGN: begin
        // bits falling off the bottom accumulate into the sticky bit
        mb_d = (diff_q > DMAX) ? {{(SW-1){1'b0}}, 1'b1} : {1'b0, mb_q[SW-1:2], |mb_q[1:0]};
        diff_d = (diff_q > DMAX) ? '0 : diff_q - E1;
        state_d = (diff_q > DMAX || diff_q == E1) ? ADD : ALIGN;
      end
      ADD: begin
        sum_d = eop_q ? {1'b0, ma_q} - {1'b0, mb_q} : {1'b0, ma_q} + {1'b0, mb_q};
        res_d = spec_q ? sres_q : '0;
        ofuf_d = 2'b00;
        state_d = (spec_q | ~|sum_d) ? DONE : NORM;
      end
      NORM: if (sum_q[SW]) begin
        sum_d = {1'b0, sum_q[SW:2], |sum_q[1:0]};
        exp_d = exp_q + E1;
        res_d = inf;
        ofuf_d = 2'b10;
        state_d = (exp_d == EMAX) ? DONE : ROUND;
      end else if (!sum_q[SW-1]) begin
        sum_d = {sum_q[SW-1:0], 1'b0};
        exp_d = exp_q - E1;
        res_d = {sign_q, {(W-1){1'b0}}};
        ofuf_d = 2'b01;
        state_d = (exp_q <= E1) ? DONE : NORM;
      end else
        state_d = ROUND;
      ROUND: begin
        res_d = (rexp >= EMAX) ? inf : {sign_q, rexp[EXP_W-1:0], rnd[MAN_W-1:0]};
        ofuf_d = (rexp >= EMAX) ? 2'b10 : 2'b00;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q <= '0;
      ofuf_q <= '0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      ofuf_q <= ofuf_d;
    end
    {sign_q, eop_q, spec_q, exp_q, diff_q} <= {sign_d, eop_d, spec_d, exp_d, diff_d};
    {ma_q, mb_q, sum_q, sres_q} <= {ma_d, mb_d, sum_d, sres_d};
  end
endmodule

// File: tb/tb_fp_add_sub_seq.sv
// tb_fp_add_sub_seq: directed and randomized checks of fp_add_sub_seq (binary16) against an exact-arithmetic model
module tb_fp_add_sub_seq;
  logic clk = 1'b0;
  logic reset, start, sub, ready, done;
  logic [15:0] a, b, result;
  logic [1:0] ofuf;
  int checks = 0;
  int errors = 0;
  logic [15:0] bx[3], by[3], br[3];
  logic bs[3];

  fp_add_sub_seq dut (.clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
                      .ready(ready), .done(done), .result(result), .ofuf(ofuf));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact value of each operand as an integer in units of 2^-24, summed, then rounded RNE.
  function automatic logic [17:0] ref_add(input logic s, input logic [15:0] x, input logic [15:0] y0);
    logic [15:0] y;
    int ex, ey, p, e, sh;
    longint va, vb, sum, mag, mant, rem, half;
    logic sg;
    y = {y0[15] ^ s, y0[14:0]};
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    if (ex == 31 || ey == 31) begin
      if (ex == 31 && ey == 31 && x[15] != y[15]) return {2'b00, 16'h7E00};
      return (ex == 31) ? {2'b00, x[15], 5'h1F, 10'h0} : {2'b00, y[15], 5'h1F, 10'h0};
    end
    if (ex == 0 && ey == 0) return {2'b00, x[15] & y[15], 15'h0};
    if (ex == 0) return {2'b00, y};
    if (ey == 0) return {2'b00, x};
    va = longint'({1'b1, x[9:0]}) << (ex - 1);
    vb = longint'({1'b1, y[9:0]}) << (ey - 1);
    if (x[15]) va = -va;
    if (y[15]) vb = -vb;
    sum = va + vb;
    if (sum == 0) return 18'h0;
    sg = sum < 0;
    mag = sg ? -sum : sum;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    e = p - 9;
    if (e < 1) return {2'b01, sg, 15'h0};
    sh = p - 10;
    mant = mag >> sh;
    rem = mag - (mant << sh);
    if (sh > 0) begin
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
    end
    if (mant == 2048) begin
      mant = 1024;
      e++;
    end
    if (e >= 31) return {2'b10, sg, 5'h1F, 10'h0};
    return {2'b00, sg, 5'(e), mant[9:0]};
  endfunction

  task automatic op_check(input string tag, input logic s, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] er, input logic [1:0] ef, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    start = 1'b1;
    sub = s;
    a = x;
    b = y;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_res"}, result, er);
    check({tag, "_ofuf"}, ofuf, ef);
  endtask

  initial begin
    int lat, k, dn, nd;
    logic prev_done;
    logic [17:0] e;
    logic [15:0] x, y;
    logic s;
    int m;
    reset = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ofuf", ofuf, 0);
    reset = 1'b0;

    op_check("one_plus_one", 1'b0, 16'h3C00, 16'h3C00, 16'h4000, 2'b00, lat);
    check("lat_one_plus_one", lat, 4);
    op_check("two_minus_one", 1'b1, 16'h4000, 16'h3C00, 16'h3C00, 2'b00, lat);
    op_check("one_minus_one", 1'b1, 16'h3C00, 16'h3C00, 16'h0000, 2'b00, lat);
    op_check("tie_even", 1'b0, 16'h3C00, 16'h1000, 16'h3C00, 2'b00, lat);
    op_check("tie_odd", 1'b0, 16'h3C01, 16'h1000, 16'h3C02, 2'b00, lat);
    op_check("above_half", 1'b0, 16'h3C00, 16'h1001, 16'h3C01, 2'b00, lat);
    op_check("overflow", 1'b0, 16'h7BFF, 16'h7BFF, 16'h7C00, 2'b10, lat);
    op_check("underflow", 1'b1, 16'h0401, 16'h0400, 16'h0000, 2'b01, lat);
    op_check("inf_minus_inf", 1'b1, 16'h7C00, 16'h7C00, 16'h7E00, 2'b00, lat);
    check("lat_special", lat, 2);
    op_check("negz_plus_zero", 1'b0, 16'h8000, 16'h0000, 16'h0000, 2'b00, lat);
    op_check("zero_plus_y", 1'b0, 16'h0000, 16'hC500, 16'hC500, 2'b00, lat);
    repeat (3) @(posedge clk);
    #1;
    check("held_result", result, 16'hC500);
    check("held_no_done", done, 0);

    for (int i = 0; i < 200; i++) begin
      x = 16'($urandom);
      s = 1'($urandom);
      m = $urandom_range(0, 3);
      y = (m == 0) ? 16'($urandom)
        : (m == 1) ? {1'($urandom), x[14:10], 10'($urandom)}
        : (m == 2) ? x : {1'($urandom), x[14:11], 11'($urandom)};
      e = ref_add(s, x, y);
      op_check($sformatf("rnd%0d", i), s, x, y, e[15:0], e[17:16], lat);
    end

    bx[0] = 16'h3C00; by[0] = 16'h3C00; bs[0] = 1'b0; br[0] = 16'h4000;
    bx[1] = 16'h4000; by[1] = 16'h3C00; bs[1] = 1'b1; br[1] = 16'h3C00;
    bx[2] = 16'h0000; by[2] = 16'hC500; bs[2] = 1'b0; br[2] = 16'hC500;
    @(negedge clk);
    start = 1'b1;
    sub = bs[0];
    a = bx[0];
    b = by[0];
    k = 0;
    dn = 0;
    prev_done = 1'b0;
    for (int c = 0; c < 300 && dn < 3; c++) begin
      @(negedge clk);
      if (done) begin
        check("b2b_pulse", prev_done, 0);
        check("b2b_res", result, br[dn]);
        dn++;
      end
      prev_done = done;
      if (ready && k < 3) begin
        if (dn > 0) check("b2b_held", result, br[dn-1]);
        k++;
        @(negedge clk);
        prev_done = done;
        if (k < 3) begin
          sub = bs[k];
          a = bx[k];
          b = by[k];
        end else
          start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_accepts", k, 3);
    check("b2b_dones", dn, 3);

    @(negedge clk);
    start = 1'b1;
    sub = 1'b0;
    a = 16'h3C00;
    b = 16'h1400;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_ofuf", ofuf, 0);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("midrst_no_stale_done", nd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
